// File: rtl/bus_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : bus_sequencer
// Brief   : Two-requester round-robin sequencer for a multiplexed addr/data bus.
// Rev     : 1.0 - initial release
// ============================================================================
module bus_sequencer (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_space,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic        dma_we,
   input  logic [1:0]  dma_space,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  rdata,
   input  logic [7:0]  bus_in,
   output logic [7:0]  bus_out,
   output logic        bus_dir,
   output logic        le_lo,
   output logic        le_hi,
   output logic        oe_n,
   output logic        we_n,
   output logic        ioc,
   output logic        iod
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ADDR_HI = 2'd1,
      S_ADDR_LO = 2'd2,
      S_DATA    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_grant_dma;
   logic        r_last_dma;
   logic        r_we;
   logic [15:0] r_addr;
   logic [1:0]  r_space;
   logic [7:0]  r_wdata;
   logic        r_hi_valid;
   logic [7:0]  r_hi_byte;
   logic [7:0]  r_bus_last;
   logic [7:0]  r_rdata;

   logic        w_any;
   logic        w_pick_dma;
   logic        w_load;
   logic [15:0] w_sel_addr;
   logic        w_sel_we;
   logic [1:0]  w_sel_space;
   logic [7:0]  w_sel_wdata;
   logic        w_sel_io;
   logic        w_hi_miss;
   logic        w_in_data;

   // Round-robin: on a tie the requester not granted last time wins.
   always_comb begin
      w_any       = cpu_req | dma_req;
      w_pick_dma  = dma_req & (~cpu_req | ~r_last_dma);
      w_sel_addr  = w_pick_dma ? dma_addr  : cpu_addr;
      w_sel_we    = w_pick_dma ? dma_we    : cpu_we;
      w_sel_space = w_pick_dma ? dma_space : cpu_space;
      w_sel_wdata = w_pick_dma ? dma_wdata : cpu_wdata;
      w_sel_io    = (w_sel_space == 2'd1) || (w_sel_space == 2'd2);
      w_hi_miss   = !r_hi_valid || (w_sel_addr[15:8] != r_hi_byte);
      w_load      = 1'b0;
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DATA: begin
            if (w_any) begin
               w_load       = 1'b1;
               w_state_next = (!w_sel_io && w_hi_miss) ? S_ADDR_HI : S_ADDR_LO;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_ADDR_HI: w_state_next = S_ADDR_LO;
         S_ADDR_LO: w_state_next = S_DATA;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_grant_dma <= 1'b0;
         r_last_dma  <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= 16'h0000;
         r_space     <= 2'd0;
         r_wdata     <= 8'h00;
         r_hi_valid  <= 1'b0;
         r_hi_byte   <= 8'h00;
         r_bus_last  <= 8'h00;
         r_rdata     <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_bus_last <= bus_out;
         r_rdata    <= rdata;
         if (w_load) begin
            r_grant_dma <= w_pick_dma;
            r_last_dma  <= w_pick_dma;
            r_addr      <= w_sel_addr;
            r_we        <= w_sel_we;
            r_space     <= w_sel_space;
            r_wdata     <= w_sel_wdata;
         end
         if (r_state == S_ADDR_HI) begin
            r_hi_valid <= 1'b1;
            r_hi_byte  <= r_addr[15:8];
         end
      end
   end

   // Acks are masked by reset so an access aborted in DATA is never acknowledged.
   always_comb begin
      bus_out   = r_bus_last;
      bus_dir   = 1'b1;
      le_lo     = 1'b0;
      le_hi     = 1'b0;
      oe_n      = 1'b1;
      we_n      = 1'b1;
      ioc       = 1'b0;
      iod       = 1'b0;
      rdata     = r_rdata;
      w_in_data = (r_state == S_DATA) && !wb_rst_i;
      cpu_ack   = w_in_data && !r_grant_dma;
      dma_ack   = w_in_data &&  r_grant_dma;
      case (r_state)
         S_ADDR_HI: begin
            le_hi   = 1'b1;
            bus_dir = 1'b0;
            bus_out = r_addr[15:8];
         end
         S_ADDR_LO: begin
            le_lo   = 1'b1;
            bus_dir = 1'b0;
            bus_out = r_addr[7:0];
         end
         S_DATA: begin
            ioc = (r_space == 2'd1);
            iod = (r_space == 2'd2);
            if (r_we) begin
               we_n    = 1'b0;
               bus_dir = 1'b0;
               bus_out = r_wdata;
            end else begin
               oe_n  = 1'b0;
               rdata = bus_in;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : tb_bus_sequencer
// Brief   : Directed, table-driven self-checking bench for bus_sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_bus_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, dma_req, cpu_we, dma_we, cpu_ack, dma_ack;
   logic [15:0] cpu_addr, dma_addr;
   logic [1:0]  cpu_space, dma_space;
   logic [7:0]  cpu_wdata, dma_wdata, rdata, bus_in, bus_out;
   logic        bus_dir, le_lo, le_hi, oe_n, we_n, ioc, iod;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_rdata;

   typedef struct {
      logic        dma;
      logic [15:0] addr;
      logic        we;
      logic [1:0]  space;
      logic [7:0]  wdata;
      logic [7:0]  bin;
      logic        exp_hi;
   } vec_t;

   vec_t tbl [10];

   bus_sequencer dut (
      .wb_clk_i (clk),      .wb_rst_i (rst),
      .cpu_req  (cpu_req),  .cpu_addr (cpu_addr), .cpu_we (cpu_we),
      .cpu_space(cpu_space),.cpu_wdata(cpu_wdata),.cpu_ack(cpu_ack),
      .dma_req  (dma_req),  .dma_addr (dma_addr), .dma_we (dma_we),
      .dma_space(dma_space),.dma_wdata(dma_wdata),.dma_ack(dma_ack),
      .rdata    (rdata),    .bus_in   (bus_in),   .bus_out(bus_out),
      .bus_dir  (bus_dir),  .le_lo    (le_lo),    .le_hi  (le_hi),
      .oe_n     (oe_n),     .we_n     (we_n),     .ioc    (ioc),
      .iod      (iod)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {le_hi, le_lo, oe_n, we_n, ioc, iod, bus_dir, cpu_ack, dma_ack}
   function automatic logic [8:0] exp_sig(input int ph, input logic we,
                                          input logic [1:0] sp, input logic dma);
      case (ph)
         1:       return 9'b1_0_1_1_0_0_0_0_0;
         2:       return 9'b0_1_1_1_0_0_0_0_0;
         3:       return {2'b00, we, ~we, sp == 2'd1, sp == 2'd2, ~we, ~dma, dma};
         default: return 9'b0_0_1_1_0_0_1_0_0;
      endcase
   endfunction

   function automatic logic [8:0] sig();
      return {le_hi, le_lo, oe_n, we_n, ioc, iod, bus_dir, cpu_ack, dma_ack};
   endfunction

   task automatic do_reset();
      rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_sig",   {7'd0, sig()}, {7'd0, exp_sig(0, 1'b0, 2'd0, 1'b0)});
      chk("reset_bus",   {8'd0, bus_out}, 16'h0000);
      chk("reset_rdata", {8'd0, rdata}, 16'h0000);
      model_rdata = 8'h00;
   endtask

   task automatic run_access(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.dma) begin
         dma_addr = v.addr; dma_we = v.we; dma_space = v.space; dma_wdata = v.wdata;
         dma_req = 1'b1;
      end else begin
         cpu_addr = v.addr; cpu_we = v.we; cpu_space = v.space; cpu_wdata = v.wdata;
         cpu_req = 1'b1;
      end
      bus_in = v.bin;
      if (v.exp_hi) begin
         tick();
         chk({tag, "_hi_sig"}, {7'd0, sig()}, {7'd0, exp_sig(1, v.we, v.space, v.dma)});
         chk({tag, "_hi_bus"}, {8'd0, bus_out}, {8'd0, v.addr[15:8]});
      end
      tick();
      chk({tag, "_lo_sig"}, {7'd0, sig()}, {7'd0, exp_sig(2, v.we, v.space, v.dma)});
      chk({tag, "_lo_bus"}, {8'd0, bus_out}, {8'd0, v.addr[7:0]});
      tick();
      chk({tag, "_data_sig"}, {7'd0, sig()}, {7'd0, exp_sig(3, v.we, v.space, v.dma)});
      if (v.we) begin
         chk({tag, "_wdata"}, {8'd0, bus_out}, {8'd0, v.wdata});
      end else begin
         model_rdata = v.bin;
         chk({tag, "_rdata"}, {8'd0, rdata}, {8'd0, v.bin});
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();
      chk({tag, "_idle_sig"}, {7'd0, sig()}, {7'd0, exp_sig(0, 1'b0, 2'd0, 1'b0)});
      chk({tag, "_idle_rdata"}, {8'd0, rdata}, {8'd0, model_rdata});
      chk({tag, "_idle_bus"}, {8'd0, bus_out}, {8'd0, v.we ? v.wdata : v.addr[7:0]});
   endtask

   initial begin
      int hi_cnt, cyc, cpu_acks, dma_acks;
      logic [15:0] a;
      logic        who;
      tbl[0] = '{1'b0, 16'h0000, 1'b0, 2'd0, 8'h00, 8'h65, 1'b1};
      tbl[1] = '{1'b1, 16'h1234, 1'b1, 2'd0, 8'hA5, 8'hEE, 1'b1};
      tbl[2] = '{1'b0, 16'h0612, 1'b0, 2'd0, 8'h00, 8'h3C, 1'b1};
      tbl[3] = '{1'b1, 16'h003A, 1'b0, 2'd2, 8'h00, 8'h5E, 1'b0};
      tbl[4] = '{1'b0, 16'h0677, 1'b0, 2'd0, 8'h00, 8'h81, 1'b0};
      tbl[5] = '{1'b0, 16'h00F0, 1'b1, 2'd1, 8'h17, 8'h00, 1'b0};
      tbl[6] = '{1'b1, 16'h0655, 1'b1, 2'd3, 8'hC3, 8'h00, 1'b0};
      tbl[7] = '{1'b0, 16'h0700, 1'b0, 2'd3, 8'h00, 8'h99, 1'b1};
      tbl[8] = '{1'b0, 16'hFF3A, 1'b1, 2'd2, 8'h42, 8'h00, 1'b0};
      tbl[9] = '{1'b0, 16'h07FF, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};

      cpu_addr = '0; cpu_we = 0; cpu_space = 0; cpu_wdata = 0;
      dma_addr = '0; dma_we = 0; dma_space = 0; dma_wdata = 0;
      bus_in = 8'h00;
      do_reset();
      for (int i = 0; i < 10; i++) run_access(tbl[i], i);

      // Streaming CPU reads with req held high across acks.
      do_reset();
      hi_cnt = 0; cyc = 0;
      cpu_we = 1'b0; cpu_space = 2'd0; cpu_req = 1'b1;
      for (int k = 0; k < 512; k++) begin
         a = k[15:0];
         cpu_addr = a;
         bus_in = a[7:0] ^ 8'h5A;
         if (a[7:0] == 8'h00) begin
            tick(); cyc++;
            if (le_hi) hi_cnt++;
            chk("stream_hi", {7'd0, sig()}, {7'd0, exp_sig(1, 1'b0, 2'd0, 1'b0)});
         end
         tick(); cyc++;
         if (le_hi) hi_cnt++;
         chk("stream_lo", {7'd0, sig()}, {7'd0, exp_sig(2, 1'b0, 2'd0, 1'b0)});
         tick(); cyc++;
         chk("stream_data", {7'd0, sig()}, {7'd0, exp_sig(3, 1'b0, 2'd0, 1'b0)});
         chk("stream_rdata", {8'd0, rdata}, {8'd0, a[7:0] ^ 8'h5A});
      end
      cpu_req = 1'b0;
      chk("stream_hi_count", hi_cnt[15:0], 16'd2);
      chk("stream_cycles", cyc[15:0], 16'd1026);
      tick();
      chk("stream_idle", {7'd0, sig()}, {7'd0, exp_sig(0, 1'b0, 2'd0, 1'b0)});

      // Both requesters pending continuously: CPU wins first tie, then alternate.
      do_reset();
      cpu_addr = 16'h20C0; dma_addr = 16'h2040;
      cpu_we = 1'b0; dma_we = 1'b0; cpu_space = 2'd0; dma_space = 2'd0;
      bus_in = 8'h11; cpu_acks = 0; dma_acks = 0;
      cpu_req = 1'b1; dma_req = 1'b1;
      for (int g = 0; g < 8; g++) begin
         who = g[0];
         if (g == 0) begin
            tick();
            chk("alt_hi", {7'd0, sig()}, {7'd0, exp_sig(1, 1'b0, 2'd0, 1'b0)});
         end
         tick();
         chk("alt_lo", {7'd0, sig()}, {7'd0, exp_sig(2, 1'b0, 2'd0, who)});
         chk("alt_lo_bus", {8'd0, bus_out}, {8'd0, who ? dma_addr[7:0] : cpu_addr[7:0]});
         tick();
         chk("alt_data", {7'd0, sig()}, {7'd0, exp_sig(3, 1'b0, 2'd0, who)});
         if (cpu_ack) cpu_acks++;
         if (dma_ack) dma_acks++;
         if (who) dma_addr = dma_addr + 16'd1;
         else     cpu_addr = cpu_addr + 16'd1;
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      chk("alt_cpu_acks", cpu_acks[15:0], 16'd4);
      chk("alt_dma_acks", dma_acks[15:0], 16'd4);
      tick();
      chk("alt_idle", {7'd0, sig()}, {7'd0, exp_sig(0, 1'b0, 2'd0, 1'b0)});

      // Reset asserted during DATA aborts the access; next access re-emits le_hi.
      do_reset();
      cpu_addr = 16'h0300; cpu_we = 1'b0; cpu_space = 2'd0; bus_in = 8'h77;
      cpu_req = 1'b1;
      tick();
      chk("abort_hi", {7'd0, sig()}, {7'd0, exp_sig(1, 1'b0, 2'd0, 1'b0)});
      tick();
      chk("abort_lo", {7'd0, sig()}, {7'd0, exp_sig(2, 1'b0, 2'd0, 1'b0)});
      tick();
      rst = 1'b1;
      #1;
      chk("abort_no_ack", {14'd0, cpu_ack, dma_ack}, 16'h0000);
      tick();
      chk("abort_rst_sig", {7'd0, sig()}, {7'd0, exp_sig(0, 1'b0, 2'd0, 1'b0)});
      chk("abort_rst_bus", {8'd0, bus_out}, 16'h0000);
      chk("abort_rst_rdata", {8'd0, rdata}, 16'h0000);
      rst = 1'b0;
      tick();
      chk("abort_rehi", {7'd0, sig()}, {7'd0, exp_sig(1, 1'b0, 2'd0, 1'b0)});
      chk("abort_rehi_bus", {8'd0, bus_out}, 16'h0003);
      tick();
      chk("abort_relo", {7'd0, sig()}, {7'd0, exp_sig(2, 1'b0, 2'd0, 1'b0)});
      tick();
      chk("abort_redata", {7'd0, sig()}, {7'd0, exp_sig(3, 1'b0, 2'd0, 1'b0)});
      chk("abort_rerdata", {8'd0, rdata}, 16'h0077);
      cpu_req = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
